vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 117 +++++++++++
 tb/tb_vram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for a shared single-port VRAM behind an external address mux.
// Define VRAM_ARB_STARVE_EN to stop back-to-back video slots from starving the CPU.
module vram_arbiter #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_cen,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_q,
  output logic          vid_valid,
  output logic          vid_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  output logic          mux_sel,
  output logic          mux_oe_n
);

  typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} state_t;

  state_t state, state_nx;
  logic   cpu_elig;
  logic   vid_win;

  // A request in flight or just acknowledged must not launch a second access.
  assign cpu_elig = cpu_req && !cpu_ack && (state != S_CPU);

`ifdef VRAM_ARB_STARVE_EN
  logic [1:0] starve_cnt;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  assign vid_win = pix_cen && !(cpu_elig && (starve_cnt == 2'd3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 2'd0;
      vid_miss   <= 1'b0;
    end else begin
      vid_miss <= pix_cen && !vid_win;
      if (cpu_ack)
        starve_cnt <= 2'd0;
      else if (pix_cen && cpu_elig && vid_win)
        starve_cnt <= sat_inc(starve_cnt);
    end
  end
`else
  assign vid_win  = pix_cen;
  assign vid_miss = 1'b0;
`endif

  always_comb begin
    state_nx = S_IDLE;
    if (vid_win)
      state_nx = S_VID;
    else if (cpu_elig)
      state_nx = S_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Memory-side controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_sel   <= 1'b0;
      mux_oe_n  <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_d     <= 8'd0;
      vid_q     <= 8'd0;
      vid_valid <= 1'b0;
      cpu_dout  <= 8'd0;
      cpu_ack   <= 1'b0;
    end else begin
      mux_oe_n <= (state_nx == S_IDLE);
      ram_we   <= 1'b0;
      case (state_nx)
        S_VID: begin
          mux_sel  <= 1'b0;
          ram_addr <= vid_addr;
        end
        S_CPU: begin
          mux_sel  <= 1'b1;
          ram_addr <= cpu_addr;
          ram_d    <= cpu_din;
          ram_we   <= cpu_we;
        end
        default: ;
      endcase

      vid_valid <= (state == S_VID);
      if (state == S_VID)
        vid_q <= ram_q;

      // ram_we still carries the latched direction during the CPU cycle.
      cpu_ack <= (state == S_CPU);
      if ((state == S_CPU) && !ram_we)
        cpu_dout <= ram_q;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM attached to the ram_* port.
module tb_vram_arbiter;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pix_cen = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0]    vid_q;
  logic          vid_valid;
  logic          vid_miss;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = 8'd0;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_d;
  logic          ram_we;
  logic [7:0]    ram_q;
  logic          mux_sel;
  logic          mux_oe_n;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_d = 8'd0;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .pix_cen(pix_cen), .vid_addr(vid_addr),
    .vid_q(vid_q), .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_d(ram_d),
    .ram_we(ram_we), .ram_q(ram_q), .mux_sel(mux_sel), .mux_oe_n(mux_oe_n)
  );

  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_d;
    else if (pre_we)
      mem[pre_addr] <= pre_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_d    = d;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_oe_n",  32'(mux_oe_n),  32'd1);
    check("rst_we",    32'(ram_we),    32'd0);
    check("rst_sel",   32'(mux_sel),   32'd0);
    check("rst_addr",  32'(ram_addr),  32'd0);
    check("rst_d",     32'(ram_d),     32'd0);
    check("rst_vq",    32'(vid_q),     32'd0);
    check("rst_vv",    32'(vid_valid), 32'd0);
    check("rst_miss",  32'(vid_miss),  32'd0);
    check("rst_dout",  32'(cpu_dout),  32'd0);
    check("rst_ack",   32'(cpu_ack),   32'd0);

    preload(11'h123, 8'hA5);
    preload(11'h040, 8'h5A);
    preload(11'h010, 8'h00);
    preload(11'h020, 8'h00);
    reset = 1'b0;
    tick();

    // Video read: address at +1, data at +2.
    pix_cen = 1'b1; vid_addr = 11'h123;
    tick();
    pix_cen = 1'b0;
    check("vid1_addr", 32'(ram_addr), 32'h123);
    check("vid1_sel",  32'(mux_sel),  32'd0);
    check("vid1_oe_n", 32'(mux_oe_n), 32'd0);
    check("vid1_we",   32'(ram_we),   32'd0);
    tick();
    check("vid2_q",    32'(vid_q),     32'hA5);
    check("vid2_vld",  32'(vid_valid), 32'd1);
    check("vid2_oe_n", 32'(mux_oe_n),  32'd1);
    tick();
    check("vid3_vld",  32'(vid_valid), 32'd0);

    // CPU write, request held through the ack cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_din = 8'h3C;
    tick();
    check("wr1_we",   32'(ram_we),   32'd1);
    check("wr1_sel",  32'(mux_sel),  32'd1);
    check("wr1_addr", 32'(ram_addr), 32'h010);
    check("wr1_d",    32'(ram_d),    32'h3C);
    check("wr1_ack",  32'(cpu_ack),  32'd0);
    tick();
    check("wr2_ack",  32'(cpu_ack),  32'd1);
    check("wr2_we",   32'(ram_we),   32'd0);
    check("wr2_mem",  32'(mem[11'h010]), 32'h3C);
    check("wr2_dout", 32'(cpu_dout), 32'h00);
    tick();
    cpu_req = 1'b0;
    check("wr3_ack",  32'(cpu_ack),  32'd0);
    check("wr3_oe_n", 32'(mux_oe_n), 32'd1);
    check("wr3_sel",  32'(mux_sel),  32'd1);
    tick();

    // Contested slot: video first, CPU read right after.
    pix_cen = 1'b1; vid_addr = 11'h123;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h040;
    tick();
    pix_cen = 1'b0;
    check("con1_sel",  32'(mux_sel),  32'd0);
    check("con1_oe_n", 32'(mux_oe_n), 32'd0);
    tick();
    check("con2_sel",  32'(mux_sel),   32'd1);
    check("con2_oe_n", 32'(mux_oe_n),  32'd0);
    check("con2_addr", 32'(ram_addr),  32'h040);
    check("con2_we",   32'(ram_we),    32'd0);
    check("con2_vld",  32'(vid_valid), 32'd1);
    check("con2_vq",   32'(vid_q),     32'hA5);
    tick();
    check("con3_ack",  32'(cpu_ack),  32'd1);
    check("con3_dout", 32'(cpu_dout), 32'h5A);
    cpu_req = 1'b0;
    tick();
    check("con4_ack",  32'(cpu_ack),  32'd0);
    check("con4_oe_n", 32'(mux_oe_n), 32'd1);
    tick();

    // Five consecutive video strobes against a pending CPU read.
    pix_cen = 1'b1; vid_addr = 11'h123;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h040;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run_oe_n", 32'(mux_oe_n), 32'd0);
`ifdef VRAM_ARB_STARVE_EN
      check("run_sel",  32'(mux_sel),  (i == 3) ? 32'd1 : 32'd0);
      check("run_miss", 32'(vid_miss), (i == 3) ? 32'd1 : 32'd0);
      if (i == 4) begin
        check("run_vld_skip", 32'(vid_valid), 32'd0);
        check("run_ack",      32'(cpu_ack),   32'd1);
        cpu_req = 1'b0;
      end
`else
      check("run_sel",  32'(mux_sel),  32'd0);
      check("run_miss", 32'(vid_miss), 32'd0);
      if (i > 0)
        check("run_vld", 32'(vid_valid), 32'd1);
`endif
    end
    pix_cen = 1'b0;
`ifndef VRAM_ARB_STARVE_EN
    tick();
    check("run_cpu_sel",  32'(mux_sel),  32'd1);
    check("run_cpu_oe_n", 32'(mux_oe_n), 32'd0);
    tick();
    check("run_ack",  32'(cpu_ack),  32'd1);
    check("run_dout", 32'(cpu_dout), 32'h5A);
    cpu_req = 1'b0;
`endif
    tick();
    tick();

    // Reset in the middle of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_din = 8'h77;
    tick();
    check("ra_we0", 32'(ram_we), 32'd1);
    reset = 1'b1;
    #1;
    check("ra_we",   32'(ram_we),   32'd0);
    check("ra_oe_n", 32'(mux_oe_n), 32'd1);
    tick();
    check("ra_ack",  32'(cpu_ack),  32'd0);
    check("ra_mem",  32'(mem[11'h020]), 32'h00);
    reset = 1'b0;
    tick();
    check("rb_we",   32'(ram_we),   32'd1);
    check("rb_addr", 32'(ram_addr), 32'h020);
    tick();
    check("rb_ack",  32'(cpu_ack),  32'd1);
    check("rb_mem",  32'(mem[11'h020]), 32'h77);
    cpu_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
